// File: rtl/tm1637_pkg.sv
// rtl/tm1637_pkg.sv - TM1637 link shared types, idle pad levels and pad helper
// Used by tm1637_byte_tx (ACK check optional via TM1637_ACK_CHECK_EN) and the hex sequencer.
package tm1637_pkg;

   localparam int TM1637_CLK_DIV_DEFAULT = 4;

   localparam logic IDLE_SCL_EN  = 1'b0;
   localparam logic IDLE_SCL_OUT = 1'b1;
   localparam logic IDLE_SDA_EN  = 1'b0;
   localparam logic IDLE_SDA_OUT = 1'b1;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RESTART,
      ST_START,
      ST_BIT_LO,
      ST_BIT_HI,
      ST_ACK_LO,
      ST_ACK_HI,
      ST_HOLD,
      ST_STOP_LO,
      ST_STOP_CLK,
      ST_STOP_END
   } tm1637_state_e;

   typedef struct packed {
      logic scl_en;
      logic scl_out;
      logic sda_en;
      logic sda_out;
   } tm1637_pads_t;

   localparam tm1637_pads_t IDLE_PADS = '{IDLE_SCL_EN, IDLE_SCL_OUT, IDLE_SDA_EN, IDLE_SDA_OUT};

   // A high line is released to the pull-up, a low line is actively driven.
   function automatic tm1637_pads_t pads_of(input logic scl_high, input logic sda_high);
      tm1637_pads_t p;
      p.scl_en  = ~scl_high;
      p.scl_out = scl_high;
      p.sda_en  = ~sda_high;
      p.sda_out = sda_high;
      return p;
   endfunction

endpackage

// File: rtl/tm1637_tick.sv
// rtl/tm1637_tick.sv - bus phase counter, tick pulses on the last cycle of each phase
// Part of tm1637_byte_tx (macro TM1637_ACK_CHECK_EN has no effect here).
module tm1637_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 16'd1;
      if (restart || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tm1637_byte_tx.sv
// rtl/tm1637_byte_tx.sv - TM1637 byte transmitter with optional start/stop framing
// Define TM1637_ACK_CHECK_EN to report a NACK from the display on ack_err.
import tm1637_pkg::*;

module tm1637_byte_tx #(
   parameter int CLK_DIV = TM1637_CLK_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       data_latch,
   input  logic [7:0] data_in,
   input  logic       start_cond,
   input  logic       stop_cond,
   output logic       busy,
   output logic       ack_err,
   output logic       scl_en,
   output logic       scl_out,
   output logic       sda_en,
   output logic       sda_out,
   input  logic       sda_in
);

   tm1637_state_e state_q;
   tm1637_pads_t  pads_q;
   logic [7:0]    data_q;
   logic [2:0]    idx_q;
   logic          stop_q;
   logic          held_q;
   logic          busy_q;
   logic          ack_err_q;
   logic          tick;

   // Counter sits at zero in IDLE so the first phase of a transfer is a full tick.
   tm1637_tick #(
      .CLK_DIV(CLK_DIV)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .restart(state_q == ST_IDLE),
      .tick   (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pads_q    <= IDLE_PADS;
         data_q    <= '0;
         idx_q     <= '0;
         stop_q    <= 1'b0;
         held_q    <= 1'b0;
         busy_q    <= 1'b0;
         ack_err_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (data_latch) begin
                  data_q    <= data_in;
                  stop_q    <= stop_cond;
                  idx_q     <= '0;
                  busy_q    <= 1'b1;
                  ack_err_q <= 1'b0;
                  if (start_cond && held_q) begin
                     state_q <= ST_RESTART;
                     pads_q  <= pads_of(1'b1, 1'b1);
                  end else if (start_cond) begin
                     state_q <= ST_START;
                     pads_q  <= pads_of(1'b1, 1'b0);
                  end else begin
                     state_q <= ST_BIT_LO;
                     pads_q  <= pads_of(1'b0, data_in[0]);
                  end
               end
            end
            ST_RESTART: if (tick) begin
               state_q <= ST_START;
               pads_q  <= pads_of(1'b1, 1'b0);
            end
            ST_START: if (tick) begin
               state_q <= ST_BIT_LO;
               pads_q  <= pads_of(1'b0, data_q[0]);
            end
            ST_BIT_LO: if (tick) begin
               state_q <= ST_BIT_HI;
               pads_q  <= pads_of(1'b1, data_q[idx_q]);
            end
            ST_BIT_HI: if (tick) begin
               idx_q <= idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_q <= ST_ACK_LO;
                  pads_q  <= pads_of(1'b0, 1'b1);
               end else begin
                  state_q <= ST_BIT_LO;
                  pads_q  <= pads_of(1'b0, data_q[idx_q + 3'd1]);
               end
            end
            ST_ACK_LO: if (tick) begin
               state_q <= ST_ACK_HI;
               pads_q  <= pads_of(1'b1, 1'b1);
            end
            ST_ACK_HI: if (tick) begin
`ifdef TM1637_ACK_CHECK_EN
               ack_err_q <= sda_in;
`endif
               state_q <= stop_q ? ST_STOP_LO : ST_HOLD;
               pads_q  <= pads_of(1'b0, 1'b0);
            end
            ST_HOLD: if (tick) begin
               state_q <= ST_IDLE;
               held_q  <= 1'b1;
               busy_q  <= 1'b0;
            end
            ST_STOP_LO: if (tick) begin
               state_q <= ST_STOP_CLK;
               pads_q  <= pads_of(1'b1, 1'b0);
            end
            ST_STOP_CLK: if (tick) begin
               state_q <= ST_STOP_END;
               pads_q  <= pads_of(1'b1, 1'b1);
            end
            ST_STOP_END: if (tick) begin
               state_q <= ST_IDLE;
               held_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               pads_q  <= IDLE_PADS;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

`ifndef TM1637_ACK_CHECK_EN
   logic unused_sda_in;
   assign unused_sda_in = sda_in;
`endif

   assign busy    = busy_q;
   assign ack_err = ack_err_q;
   assign scl_en  = pads_q.scl_en;
   assign scl_out = pads_q.scl_out;
   assign sda_en  = pads_q.sda_en;
   assign sda_out = pads_q.sda_out;

endmodule

// File: tb/tb_tm1637_byte_tx.sv
// tb/tb_tm1637_byte_tx.sv - directed checks of tm1637_byte_tx at CLK_DIV=4
// Expected ack_err follows TM1637_ACK_CHECK_EN.
module tb_tm1637_byte_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       data_latch;
   logic [7:0] data_in;
   logic       start_cond;
   logic       stop_cond;
   logic       sda_in;
   logic       busy;
   logic       ack_err;
   logic       scl_en;
   logic       scl_out;
   logic       sda_en;
   logic       sda_out;

   always #5 clk = ~clk;

   tm1637_byte_tx #(
      .CLK_DIV(4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .data_latch(data_latch),
      .data_in   (data_in),
      .start_cond(start_cond),
      .stop_cond (stop_cond),
      .busy      (busy),
      .ack_err   (ack_err),
      .scl_en    (scl_en),
      .scl_out   (scl_out),
      .sda_en    (sda_en),
      .sda_out   (sda_out),
      .sda_in    (sda_in)
   );

`ifdef TM1637_ACK_CHECK_EN
   localparam logic NACK_EXP = 1'b1;
`else
   localparam logic NACK_EXP = 1'b0;
`endif

   wire scl_l = scl_en ? scl_out : 1'b1;
   wire sda_l = sda_en ? sda_out : 1'b1;

   int          vecs = 0;
   int          miscmp = 0;
   logic [15:0] rise_bits;
   int          rise_cnt;
   int          busy_cnt;
   int          start_cnt;
   int          stop_cnt;
   logic        timed_out;
   logic        ack_first;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscmp++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sends one byte and records SDA at every SCL rise, start/stop edges and busy length.
   task automatic xfer(input logic [7:0] b, input logic st, input logic sp,
                       input int latch_at, input int rst_at);
      logic ps;
      logic pd;
      rise_bits = '0;
      rise_cnt  = 0;
      busy_cnt  = 0;
      start_cnt = 0;
      stop_cnt  = 0;
      timed_out = 1'b1;
      data_in    = b;
      start_cond = st;
      stop_cond  = sp;
      data_latch = 1'b1;
      ps = scl_l;
      pd = sda_l;
      @(negedge clk);
      data_latch = 1'b0;
      data_in    = ~b;
      start_cond = ~st;
      stop_cond  = ~sp;
      ack_first  = ack_err;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (scl_l && !ps) begin
            rise_bits = {rise_bits[14:0], sda_l};
            rise_cnt++;
         end
         if (scl_l && ps && pd && !sda_l) start_cnt++;
         if (scl_l && ps && !pd && sda_l) stop_cnt++;
         ps = scl_l;
         pd = sda_l;
         if (!busy) begin
            timed_out = 1'b0;
            break;
         end
         busy_cnt++;
         if (cyc == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            timed_out = 1'b0;
            break;
         end
         data_latch = (cyc == latch_at);
         if (cyc == latch_at) begin
            data_in    = 8'hFF;
            start_cond = 1'b1;
            stop_cond  = 1'b0;
         end
         @(negedge clk);
      end
      data_latch = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      data_latch = 1'b0;
      data_in = 8'h00;
      start_cond = 1'b0;
      stop_cond = 1'b0;
      sda_in = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outs", {busy, ack_err, scl_en, scl_out, sda_en, sda_out}, 6'b000101);
      rst = 1'b0;
      @(negedge clk);

      xfer(8'h40, 1'b1, 1'b1, -1, -1);
      check("a_timeout", timed_out, 1'b0);
      check("a_busy", busy_cnt, 88);
      check("a_bits", rise_bits[9:2], 8'b00000010);
      check("a_trace", rise_bits, 16'h000A);
      check("a_rises", rise_cnt, 10);
      check("a_start_stop", {start_cnt[3:0], stop_cnt[3:0]}, 8'h11);
      check("a_ack_err", ack_err, 1'b0);
      check("a_bus", {scl_en, scl_out, sda_en, sda_out}, 4'b0101);

      xfer(8'hC0, 1'b1, 1'b0, -1, -1);
      check("b1_timeout", timed_out, 1'b0);
      check("b1_busy", busy_cnt, 80);
      check("b1_trace", rise_bits, 16'h0007);
      check("b1_rises", rise_cnt, 9);
      check("b1_start_stop", {start_cnt[3:0], stop_cnt[3:0]}, 8'h10);
      check("b1_bus_held", {scl_en, scl_out, sda_en, sda_out}, 4'b1010);
      repeat (5) @(negedge clk);
      check("b1_idle_held", {busy, scl_en, scl_out, sda_en, sda_out}, 5'b01010);

      xfer(8'h3F, 1'b0, 1'b1, -1, -1);
      check("b2_timeout", timed_out, 1'b0);
      check("b2_busy", busy_cnt, 84);
      check("b2_trace", rise_bits, 16'h03F2);
      check("b2_rises", rise_cnt, 10);
      check("b2_start_stop", {start_cnt[3:0], stop_cnt[3:0]}, 8'h01);
      check("b2_bus", {scl_en, scl_out, sda_en, sda_out}, 4'b0101);

      sda_in = 1'b1;
      xfer(8'h55, 1'b1, 1'b0, -1, -1);
      check("n_timeout", timed_out, 1'b0);
      check("n_busy", busy_cnt, 80);
      check("n_trace", rise_bits, 16'h0155);
      check("n_ack_err", ack_err, NACK_EXP);
      sda_in = 1'b0;
      repeat (20) @(negedge clk);
      check("n_ack_sticky", ack_err, NACK_EXP);
      check("n_bus_held", {scl_en, scl_out, sda_en, sda_out}, 4'b1010);

      xfer(8'h8F, 1'b1, 1'b1, -1, -1);
      check("c_ack_cleared", ack_first, 1'b0);
      check("c_timeout", timed_out, 1'b0);
      check("c_busy", busy_cnt, 92);
      check("c_trace", rise_bits, 16'h07C6);
      check("c_rises", rise_cnt, 11);
      check("c_start_stop", {start_cnt[3:0], stop_cnt[3:0]}, 8'h11);
      check("c_ack_err", ack_err, 1'b0);
      check("c_bus", {scl_en, scl_out, sda_en, sda_out}, 4'b0101);

      xfer(8'h40, 1'b1, 1'b1, 30, -1);
      check("i_timeout", timed_out, 1'b0);
      check("i_busy", busy_cnt, 88);
      check("i_trace", rise_bits, 16'h000A);
      check("i_start_stop", {start_cnt[3:0], stop_cnt[3:0]}, 8'h11);
      repeat (3) @(negedge clk);
      check("i_no_retrigger", busy, 1'b0);

      sda_in = 1'b1;
      xfer(8'h40, 1'b1, 1'b1, -1, 33);
      check("r_abort_point", {busy_cnt[7:0], rise_cnt[7:0]}, 16'h2204);
      check("r_reset_outs", {busy, ack_err, scl_en, scl_out, sda_en, sda_out}, 6'b000101);
      @(negedge clk);
      xfer(8'h40, 1'b1, 1'b1, -1, -1);
      check("r2_timeout", timed_out, 1'b0);
      check("r2_busy", busy_cnt, 88);
      check("r2_trace", rise_bits, 16'h000A);
      check("r2_ack_err", ack_err, NACK_EXP);
      check("r2_bus", {scl_en, scl_out, sda_en, sda_out}, 4'b0101);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
      $finish;
   end

endmodule
